uart_word_tx: RTL

- Serial transmitter at the far end of the processor's serial-output handshake (SerialOutEn / SerialData / TX_flag).
- Captures one WORD_LENGTH-bit result word and sends it as WORD_LENGTH/8 UART frames: 8N1, least-significant byte first.
- Returns a one-cycle TX_flag pulse when the whole word has left the line, which releases the control unit.

---
 rtl/uart_word_tx_if.sv | 39 +++
 rtl/uart_word_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : uart_word_tx_if                                         |
// | Purpose  : Serial-output handshake between the control unit and    |
// |            the word-wide UART transmitter.                         |
// | Signals  : SerialOutEn  control unit -> tx, start request (edge)   |
// |            SerialData   control unit -> tx, word to send           |
// |            tx           tx -> line, UART serial output, idle high  |
// |            TX_flag      tx -> control unit, one-cycle done pulse   |
// |            busy         tx -> control unit, transfer in progress   |
// | Modports : master (control unit side), slave (transmitter side)    |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
interface uart_word_tx_if #(
    parameter int WORD_LENGTH = 32
);
    logic                   SerialOutEn;
    logic [WORD_LENGTH-1:0] SerialData;
    logic                   tx;
    logic                   TX_flag;
    logic                   busy;

    modport master (
        output SerialOutEn,
        output SerialData,
        input  tx,
        input  TX_flag,
        input  busy
    );

    modport slave (
        input  SerialOutEn,
        input  SerialData,
        output tx,
        output TX_flag,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_word_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : uart_word_tx                                            |
// | Purpose  : Captures one WORD_LENGTH-bit word on a rising edge of   |
// |            SerialOutEn and sends it as WORD_LENGTH/8 UART 8N1      |
// |            frames, least-significant byte first, then pulses       |
// |            TX_flag for one cycle.                                  |
// | Ports    : clk    system clock, rising edge                        |
// |            reset  synchronous, active-high                         |
// |            bus    uart_word_tx_if.slave (SerialOutEn, SerialData,  |
// |                   tx, TX_flag, busy)                               |
// | Params   : WORD_LENGTH  word width, multiple of 8                  |
// |            BAUD_DIV     clk cycles per UART bit, >= 2              |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module uart_word_tx #(
    parameter int WORD_LENGTH = 32,
    parameter int BAUD_DIV    = 434
) (
    input  logic          clk,
    input  logic          reset,
    uart_word_tx_if.slave bus
);

    localparam int NBYTES   = WORD_LENGTH / 8;
    localparam int c_BAUD_W = $clog2(BAUD_DIV);
    localparam int c_BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(BAUD_DIV - 1);
    localparam logic [c_BYTE_W-1:0] c_BYTE_LAST = c_BYTE_W'(NBYTES - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_START = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_STOP  = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    // Registered state
    logic [2:0]             r_state;
    logic                   r_en_d;
    logic [WORD_LENGTH-1:0] r_word;     // bytes still to be sent, next one in [7:0]
    logic [7:0]             r_shift;
    logic [2:0]             r_bit_cnt;
    logic [c_BYTE_W-1:0]    r_byte_cnt;
    logic [c_BAUD_W-1:0]    r_baud_cnt;
    logic                   r_tx;
    logic                   r_flag;
    logic                   r_busy;

    // Next-state values
    logic [2:0]             w_state;
    logic                   w_en_d;
    logic [WORD_LENGTH-1:0] w_word;
    logic [7:0]             w_shift;
    logic [2:0]             w_bit_cnt;
    logic [c_BYTE_W-1:0]    w_byte_cnt;
    logic [c_BAUD_W-1:0]    w_baud_cnt;
    logic                   w_tx;
    logic                   w_flag;
    logic                   w_busy;

    logic                   w_accept;
    logic                   w_bit_end;

    assign w_accept  = bus.SerialOutEn & ~r_en_d;
    assign w_bit_end = (r_baud_cnt == c_BAUD_LAST);

    always_comb begin
        w_state    = r_state;
        w_en_d     = bus.SerialOutEn;
        w_word     = r_word;
        w_shift    = r_shift;
        w_bit_cnt  = r_bit_cnt;
        w_byte_cnt = r_byte_cnt;
        w_baud_cnt = r_baud_cnt;
        w_tx       = r_tx;
        w_flag     = r_flag;
        w_busy     = r_busy;

        case (r_state)
            c_IDLE: begin
                w_baud_cnt = '0;
                w_tx       = 1'b1;
                w_flag     = 1'b0;
                w_busy     = 1'b0;
                if (w_accept) begin
                    // Byte 0 goes straight into the shifter; the rest waits in r_word.
                    w_word     = bus.SerialData >> 8;
                    w_shift    = bus.SerialData[7:0];
                    w_byte_cnt = '0;
                    w_bit_cnt  = '0;
                    w_tx       = 1'b0;
                    w_busy     = 1'b1;
                    w_state    = c_START;
                end
            end

            c_START: begin
                if (w_bit_end) begin
                    w_baud_cnt = '0;
                    w_bit_cnt  = '0;
                    w_tx       = r_shift[0];
                    w_state    = c_DATA;
                end else begin
                    w_baud_cnt = r_baud_cnt + 1'b1;
                end
            end

            c_DATA: begin
                if (w_bit_end) begin
                    w_baud_cnt = '0;
                    w_shift    = r_shift >> 1;
                    if (r_bit_cnt == 3'd7) begin
                        w_tx    = 1'b1;
                        w_state = c_STOP;
                    end else begin
                        // Register the bit that becomes r_shift[0] after this shift.
                        w_bit_cnt = r_bit_cnt + 1'b1;
                        w_tx      = r_shift[1];
                    end
                end else begin
                    w_baud_cnt = r_baud_cnt + 1'b1;
                end
            end

            c_STOP: begin
                if (w_bit_end) begin
                    w_baud_cnt = '0;
                    if (r_byte_cnt < c_BYTE_LAST) begin
                        // Next frame starts with no idle gap.
                        w_byte_cnt = r_byte_cnt + 1'b1;
                        w_shift    = r_word[7:0];
                        w_word     = r_word >> 8;
                        w_tx       = 1'b0;
                        w_state    = c_START;
                    end else begin
                        w_flag  = 1'b1;
                        w_state = c_DONE;
                    end
                end else begin
                    w_baud_cnt = r_baud_cnt + 1'b1;
                end
            end

            c_DONE: begin
                w_baud_cnt = '0;
                w_tx       = 1'b1;
                w_flag     = 1'b0;
                w_busy     = 1'b0;
                w_state    = c_IDLE;
            end

            default: begin
                w_baud_cnt = '0;
                w_tx       = 1'b1;
                w_flag     = 1'b0;
                w_busy     = 1'b0;
                w_state    = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_en_d     <= 1'b0;
            r_word     <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
            r_flag     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_en_d     <= w_en_d;
            r_word     <= w_word;
            r_shift    <= w_shift;
            r_bit_cnt  <= w_bit_cnt;
            r_byte_cnt <= w_byte_cnt;
            r_baud_cnt <= w_baud_cnt;
            r_tx       <= w_tx;
            r_flag     <= w_flag;
            r_busy     <= w_busy;
        end
    end

    assign bus.tx      = r_tx;
    assign bus.TX_flag = r_flag;
    assign bus.busy    = r_busy;

endmodule
`default_nettype wire
